// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; serves as absolute value when
// neg_i is driven by the operand's sign bit.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] value_o
);

    always_comb begin
        value_o = value_i;
        if (neg_i) begin
            value_o = (~value_i) + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Unsigned iterative core on operand magnitudes, signs applied in FIX.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned      CNT_W    = $clog2(MD_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    md_op_t             op_in;
    logic               signed_in;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               is_mul_q;
    logic               div_zero;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign op_in     = md_op_t'(Op);
    assign signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign in_neg_a  = signed_in & SrcA[WIDTH-1];
    assign in_neg_b  = signed_in & SrcB[WIDTH-1];
    assign is_mul_q  = (op_q == MD_MULT) || (op_q == MD_MULTU);
    assign div_zero  = (mag_b_q == '0);

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value_i (SrcA),
        .neg_i   (in_neg_a),
        .value_o (abs_a)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value_i (SrcB),
        .neg_i   (in_neg_b),
        .value_o (abs_b)
    );

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value_i (acc_q),
        .neg_i   (neg_a_q ^ neg_b_q),
        .value_o (prod_fixed)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value_i (acc_q[WIDTH-1:0]),
        .neg_i   (neg_a_q ^ neg_b_q),
        .value_o (quo_fixed)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i (rem_q),
        .neg_i   (neg_a_q),
        .value_o (rem_fixed)
    );

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in;
    // the partial remainder is always below the divisor, so WIDTH bits hold
    // it between steps and the WIDTH+1-bit trial lives only in div_shift.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        srca_d  = srca_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = op_in;
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    srca_d  = SrcA;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    cnt_d   = '0;
                    rem_d   = '0;
                    if ((op_in == MD_MULT) || (op_in == MD_MULTU)) begin
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                    end
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    if (HiWe) hi_d = WriteData;
                    if (LoWe) lo_d = WriteData;
                end
            end

            CALC: begin
                if (is_mul_q) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_mul_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (div_zero) begin
                    hi_d = srca_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            op_q    <= MD_MULT;
            cnt_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            srca_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            srca_q  <= srca_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
